// File: rtl/snd_pkg.sv
// Shared types and width helpers for the stereo mixer / sigma-delta DAC.
package snd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mix_state_t;

  // Accumulator width that can hold NCH full-scale products without overflow.
  function automatic int acc_width(input int w, input int volw, input int nch);
    return w + volw + $clog2(nch);
  endfunction

endpackage

// File: rtl/sd_dac.sv
// First-order sigma-delta modulator: carry out of err + pcm is the output bit.
module sd_dac #(
  parameter int OUTW = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [OUTW-1:0] i_pcm,
  output logic            o_pwm
);

  logic [OUTW-1:0] r_err;
  logic            r_pwm;
  logic [OUTW:0]   w_sum;

  assign w_sum = {1'b0, r_err} + {1'b0, i_pcm};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_err <= w_sum[OUTW-1:0];
      r_pwm <= w_sum[OUTW];
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/stereo_mixer_sd.sv
// NCH-channel stereo mixer: per-channel L/R volume, serial MAC once per sample
// tick, saturated PCM output and one sigma-delta bitstream per side.
module stereo_mixer_sd
  import snd_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int W     = 8,
  parameter int VOLW  = 4,
  parameter int OUTW  = 12,
  parameter int CEDIV = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NCH*W-1:0]        ch_data,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_addr,
  input  logic [2*VOLW-1:0]       cfg_data,
  output logic [OUTW-1:0]         pcm_l,
  output logic [OUTW-1:0]         pcm_r,
  output logic                    pcm_valid,
  output logic                    clip_l,
  output logic                    clip_r,
  output logic                    pwm_l,
  output logic                    pwm_r,
  output logic [1:0]              dbg_state
);

  localparam int IW = $clog2(NCH);
  localparam int AW = acc_width(W, VOLW, NCH);
  localparam int PW = W + VOLW;
  localparam int DW = $clog2(CEDIV);
  localparam logic [IW:0] NCH_L = (IW+1)'(NCH);

  if (CEDIV < NCH + 2) begin : g_bad_cediv
    $error("stereo_mixer_sd: CEDIV must be at least NCH+2");
  end
  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("stereo_mixer_sd: NCH must be in 2..16");
  end

  mix_state_t r_state, w_state_nxt;

  logic [DW-1:0]   r_div;
  logic            w_tick;
  logic [VOLW-1:0] r_vol_l    [NCH];
  logic [VOLW-1:0] r_vol_r    [NCH];
  logic [W-1:0]    r_sh_ch    [NCH];
  logic [VOLW-1:0] r_sh_vol_l [NCH];
  logic [VOLW-1:0] r_sh_vol_r [NCH];
  logic [IW-1:0]   r_idx;
  logic            w_last;
  logic [AW-1:0]   r_acc_l, r_acc_r;
  logic [PW-1:0]   w_prod_l, w_prod_r;
  logic [OUTW-1:0] w_sat_l, w_sat_r;
  logic            w_clip_l, w_clip_r;
  logic [OUTW-1:0] r_pcm_l, r_pcm_r;
  logic            r_pcm_valid, r_clip_l, r_clip_r;

  assign w_tick = (r_div == DW'(CEDIV - 1));
  assign w_last = (r_idx == IW'(NCH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DW'(1);
  end

  // Out-of-range addresses only exist when NCH is not a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_vol_l[i] <= '1;
        r_vol_r[i] <= '1;
      end
    end else if (cfg_we && ({1'b0, cfg_addr} < NCH_L)) begin
      r_vol_l[cfg_addr] <= cfg_data[2*VOLW-1:VOLW];
      r_vol_r[cfg_addr] <= cfg_data[VOLW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_tick) w_state_nxt = ACC;
      ACC:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_prod_l = PW'(r_sh_ch[r_idx]) * PW'(r_sh_vol_l[r_idx]);
  assign w_prod_r = PW'(r_sh_ch[r_idx]) * PW'(r_sh_vol_r[r_idx]);

  if (AW > OUTW) begin : g_sat
    assign w_clip_l = |r_acc_l[AW-1:OUTW];
    assign w_clip_r = |r_acc_r[AW-1:OUTW];
    assign w_sat_l  = w_clip_l ? '1 : r_acc_l[OUTW-1:0];
    assign w_sat_r  = w_clip_r ? '1 : r_acc_r[OUTW-1:0];
  end else begin : g_ext
    assign w_clip_l = 1'b0;
    assign w_clip_r = 1'b0;
    assign w_sat_l  = OUTW'(r_acc_l);
    assign w_sat_r  = OUTW'(r_acc_r);
  end

  // pcm_valid is a one-clk strobe; the consumer has no ready and must take it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_sh_ch[i]    <= '0;
        r_sh_vol_l[i] <= '0;
        r_sh_vol_r[i] <= '0;
      end
      r_idx       <= '0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_pcm_l     <= '0;
      r_pcm_r     <= '0;
      r_clip_l    <= 1'b0;
      r_clip_r    <= 1'b0;
      r_pcm_valid <= 1'b0;
    end else begin
      r_pcm_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            for (int i = 0; i < NCH; i++) begin
              r_sh_ch[i]    <= ch_data[i*W +: W];
              r_sh_vol_l[i] <= r_vol_l[i];
              r_sh_vol_r[i] <= r_vol_r[i];
            end
            r_idx   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
          end
        end
        ACC: begin
          r_acc_l <= r_acc_l + AW'(w_prod_l);
          r_acc_r <= r_acc_r + AW'(w_prod_r);
          if (!w_last) r_idx <= r_idx + IW'(1);
        end
        DONE: begin
          r_pcm_l     <= w_sat_l;
          r_pcm_r     <= w_sat_r;
          r_clip_l    <= w_clip_l;
          r_clip_r    <= w_clip_r;
          r_pcm_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sd_dac #(.OUTW(OUTW)) u_dac_l (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_pcm   (r_pcm_l),
    .o_pwm   (pwm_l)
  );

  sd_dac #(.OUTW(OUTW)) u_dac_r (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_pcm   (r_pcm_r),
    .o_pwm   (pwm_r)
  );

  assign pcm_l     = r_pcm_l;
  assign pcm_r     = r_pcm_r;
  assign pcm_valid = r_pcm_valid;
  assign clip_l    = r_clip_l;
  assign clip_r    = r_clip_r;
  assign dbg_state = r_state;

endmodule
